ifetch_stage: RTL and testbench

Parametrised instruction-fetch stage. It owns the word-addressed PC and a dual-clock instruction RAM that the UART programmer writes. It presents instructions to decode with a valid flag. Over the previous fetch unit it adds:
- stall and single-step control
- sign-extended branch offsets
- out-of-range fault detection
- a separate programming clock port instead of a muxed memory clock.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/imem_dp.sv | 28 ++
 rtl/ifetch_stage.sv | 111 +++++++++++
 tb/tb_ifetch_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: mode encodings used by the fetch stage and the controller.
package cpu_pkg;

    typedef enum logic [3:0] {
        MODE_RUN   = 4'd5,
        MODE_CLEAR = 4'd6,
        MODE_STEP  = 4'd7
    } cpu_mode_t;

endpackage

// File: rtl/imem_dp.sv
// Dual-clock instruction RAM: port A synchronous read on the CPU clock,
// port B write-only on the programmer clock.
module imem_dp #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              clk_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_a) begin
        rdata_a <= mem[addr_a];
    end

    always_ff @(posedge clk_b) begin
        if (we_b) begin
            mem[addr_b] <= wdata_b;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC sequencing with stall/step, jump/branch redirects,
// out-of-range fault detection and a programmer-writable instruction RAM.
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int PC_W   = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [3:0]        mode_i,
    input  logic              stall_i,
    input  logic              step_i,
    input  logic              j_valid_i,
    input  logic [25:0]       j_addr_i,
    input  logic              b_valid_i,
    input  logic [15:0]       b_off_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc_plus1_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              fault_o,
    input  logic              upg_rst_i,
    input  logic              upg_clk_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [DATA_W-1:0] upg_dat_i,
    input  logic              upg_done_i
);

    logic            upg_mode;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, target;
    logic            fault_q, fault_d;
    logic            valid_q, valid_d;
    logic [2:0]      step_sync;
    logic            step_edge, can_adv, adv, out_of_range;

    assign upg_mode = ~upg_rst_i & ~upg_done_i;

    // Two flops synchronise the button, the third remembers the previous level.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) step_sync <= '0;
        else         step_sync <= {step_sync[1:0], step_i};
    end

    assign step_edge = step_sync[1] & ~step_sync[2];

    always_comb begin
        pc_inc  = pc_q + PC_W'(1);
        can_adv = valid_q & ~stall_i;
        adv     = 1'b0;
        if (mode_i == MODE_RUN)       adv = can_adv;
        else if (mode_i == MODE_STEP) adv = can_adv & step_edge;

        if (j_valid_i)      target = PC_W'(j_addr_i);
        else if (b_valid_i) target = pc_inc + PC_W'($signed(b_off_i));
        else                target = pc_inc;

        // Widened compare so negative branch wrap-around lands above DEPTH.
        out_of_range = {1'b0, target} >= (PC_W+1)'(DEPTH);

        pc_d    = pc_q;
        fault_d = fault_q;
        if (upg_mode || mode_i == MODE_CLEAR) begin
            pc_d = '0;
            if (mode_i == MODE_CLEAR) fault_d = 1'b0;
        end else if (adv) begin
            if (out_of_range) begin
                pc_d    = '0;
                fault_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end

        valid_d = ~upg_mode & (pc_d == pc_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q    <= '0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            valid_q <= valid_d;
        end
    end

    imem_dp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .clk_a   (clk_i),
        .addr_a  (pc_q[ADDR_W-1:0]),
        .rdata_a (instr_o),
        .clk_b   (upg_clk_i),
        .we_b    (upg_mode & upg_wen_i),
        .addr_b  (upg_adr_i),
        .wdata_b (upg_dat_i)
    );

    assign pc_o          = pc_q;
    assign pc_plus1_o    = pc_inc;
    assign instr_valid_o = valid_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: expected fetch presentations are queued by
// the stimulus and checked by a monitor on each new valid instruction.
module tb_ifetch_stage;
    import cpu_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2**ADDR_W;
    localparam int PC_W   = 32;
    localparam int NPROG  = 64;

    logic              clk = 1'b0, upg_clk = 1'b0;
    logic              reset_i, stall_i, step_i, j_valid_i, b_valid_i;
    logic [3:0]        mode_i;
    logic [25:0]       j_addr_i;
    logic [15:0]       b_off_i;
    logic [PC_W-1:0]   pc_o, pc_plus1_o;
    logic [DATA_W-1:0] instr_o;
    logic              instr_valid_o, fault_o;
    logic              upg_rst_i, upg_wen_i, upg_done_i;
    logic [ADDR_W-1:0] upg_adr_i;
    logic [DATA_W-1:0] upg_dat_i;

    always #5 clk = ~clk;
    always #7 upg_clk = ~upg_clk;

    ifetch_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PC_W   (PC_W)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .mode_i        (mode_i),
        .stall_i       (stall_i),
        .step_i        (step_i),
        .j_valid_i     (j_valid_i),
        .j_addr_i      (j_addr_i),
        .b_valid_i     (b_valid_i),
        .b_off_i       (b_off_i),
        .pc_o          (pc_o),
        .pc_plus1_o    (pc_plus1_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .fault_o       (fault_o),
        .upg_rst_i     (upg_rst_i),
        .upg_clk_i     (upg_clk),
        .upg_wen_i     (upg_wen_i),
        .upg_adr_i     (upg_adr_i),
        .upg_dat_i     (upg_dat_i),
        .upg_done_i    (upg_done_i)
    );

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
        logic              fault;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [NPROG];
    int                n_vec = 0, n_miss = 0;
    logic              prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void expect_fetch(input logic [PC_W-1:0] pc, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.instr = model[pc];
        e.fault = fault;
        sb.push_back(e);
    endfunction

    // Monitor: every rising of instr_valid_o is one fetch presentation.
    always @(negedge clk) begin
        if (instr_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_presentation", {32'd0, pc_o}, 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pres_pc", {32'd0, pc_o}, {32'd0, e.pc});
                check("pres_instr", {32'd0, instr_o}, {32'd0, e.instr});
                check("pres_fault", {63'd0, fault_o}, {63'd0, e.fault});
            end
        end
        prev_valid = instr_valid_o;
    end

    task automatic wait_valid(input string name);
        for (int unsigned i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_valid_o === 1'b1) return;
        end
        check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Issue one advance in RUN mode from a valid negedge, then return to an idle mode.
    task automatic run_one(input logic jv, input logic [25:0] ja, input logic bv, input logic [15:0] bo);
        wait_valid("run_one");
        mode_i = MODE_RUN; j_valid_i = jv; j_addr_i = ja; b_valid_i = bv; b_off_i = bo;
        @(posedge clk); #1;
        mode_i = 4'd0; j_valid_i = 1'b0; b_valid_i = 1'b0;
    endtask

    task automatic step_pulse();
        @(posedge clk); #1 step_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 step_i = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        int cnt;
        reset_i = 1'b1; mode_i = 4'd0; stall_i = 1'b0; step_i = 1'b0;
        j_valid_i = 1'b0; j_addr_i = '0; b_valid_i = 1'b0; b_off_i = '0;
        upg_rst_i = 1'b1; upg_wen_i = 1'b0; upg_done_i = 1'b0; upg_adr_i = '0; upg_dat_i = '0;
        for (int k = 0; k < NPROG; k++) model[k] = DATA_W'(k + 32'h100);

        repeat (3) @(negedge clk);
        check("reset_pc", {32'd0, pc_o}, 64'd0);
        check("reset_valid", {63'd0, instr_valid_o}, 64'd0);
        check("reset_fault", {63'd0, fault_o}, 64'd0);

        // Enter programming mode, then release CPU reset.
        upg_rst_i = 1'b0;
        @(negedge clk) reset_i = 1'b0;
        for (int k = 0; k < NPROG; k++) begin
            @(posedge upg_clk); #1;
            upg_wen_i = 1'b1; upg_adr_i = ADDR_W'(k); upg_dat_i = model[k];
        end
        @(posedge upg_clk); #1 upg_wen_i = 1'b0;
        expect_fetch(0, 1'b0);
        @(posedge upg_clk); #1 upg_done_i = 1'b1;

        // Free run 0 -> 10: one new instruction every two cycles.
        wait_valid("first_fetch");
        for (int p = 1; p <= 10; p++) expect_fetch(PC_W'(p), 1'b0);
        mode_i = MODE_RUN;
        cnt = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (instr_valid_o === 1'b1 && pc_o == 10) break;
        end
        mode_i = 4'd0;
        check("run_cycles_0_to_10", 64'(cnt), 64'd20);

        // Branches: 10+1-6 = 5; 2+1-8 wraps negative and faults.
        expect_fetch(5, 1'b0);  run_one(1'b0, '0, 1'b1, 16'hFFFA);
        expect_fetch(2, 1'b0);  run_one(1'b1, 26'd2, 1'b0, '0);
        expect_fetch(0, 1'b1);  run_one(1'b0, '0, 1'b1, 16'hFFF8);
        wait_valid("branch_fault");
        mode_i = MODE_CLEAR;
        repeat (2) @(negedge clk);
        check("clear_fault_1", {63'd0, fault_o}, 64'd0);
        mode_i = 4'd0;

        // Jump beats branch; jump to DEPTH faults.
        expect_fetch(3, 1'b0);  run_one(1'b1, 26'd3, 1'b0, '0);
        expect_fetch(40, 1'b0); run_one(1'b1, 26'd40, 1'b1, 16'd5);
        expect_fetch(0, 1'b1);  run_one(1'b1, 26'(DEPTH), 1'b0, '0);
        wait_valid("jump_fault");
        mode_i = MODE_CLEAR;
        repeat (2) @(negedge clk);
        check("clear_fault_2", {63'd0, fault_o}, 64'd0);
        check("clear_pc", {32'd0, pc_o}, 64'd0);
        mode_i = 4'd0;

        // STEP: three pulses, the middle one under stall is dropped.
        @(negedge clk) mode_i = MODE_STEP;
        expect_fetch(1, 1'b0);
        step_pulse();
        stall_i = 1'b1;
        step_pulse();
        stall_i = 1'b0;
        expect_fetch(2, 1'b0);
        step_pulse();
        @(negedge clk);
        check("step_pc", {32'd0, pc_o}, 64'd2);
        mode_i = 4'd0;

        // Stall in RUN holds everything for 5 cycles.
        wait_valid("stall_entry");
        mode_i = MODE_RUN; stall_i = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pc", {32'd0, pc_o}, 64'd2);
            check("stall_instr", {32'd0, instr_o}, 64'h102);
            check("stall_valid", {63'd0, instr_valid_o}, 64'd1);
        end
        mode_i = 4'd0; stall_i = 1'b0;

        // Asynchronous reset mid-cycle at pc=7.
        expect_fetch(7, 1'b0); run_one(1'b1, 26'd7, 1'b0, '0);
        wait_valid("pc7");
        @(posedge clk); #3 reset_i = 1'b1;
        #1;
        check("async_reset_pc", {32'd0, pc_o}, 64'd0);
        check("async_reset_valid", {63'd0, instr_valid_o}, 64'd0);
        repeat (2) @(negedge clk);
        expect_fetch(0, 1'b0);
        reset_i = 1'b0;

        for (int unsigned i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
